// File: rtl/pift_pkg.sv
// Shared helpers for the PIFT taint-tracking library: pointer width, count type
// and control-taint widening.
package pift_pkg;

    localparam int PIFT_MAX_W      = 1024;
    localparam int PIFT_FIFO_DEPTH = 8;

    function automatic int pift_ptr_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < depth) w = w + 1;
        end
        return w;
    endfunction

    // One extra bit so a count can reach DEPTH itself.
    typedef logic [pift_ptr_w(PIFT_FIFO_DEPTH):0] pift_cnt_t;

    // Callers size-cast the result down to their own data width.
    function automatic logic [PIFT_MAX_W-1:0] pift_widen(input logic t);
        return {PIFT_MAX_W{t}};
    endfunction

endpackage

// File: rtl/taintcell_fifo_mem.sv
// Storage for taintcell_fifo: data array (never reset) and taint shadow array
// (async-cleared), one write port and one asynchronous read port.
module taintcell_fifo_mem
    import pift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             pos_clk,
    input  logic             pos_arst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] wtaint_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] rtaint_o
);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] taint_q [DEPTH];

    always_ff @(posedge pos_clk) begin
        if (we_i) data_q[waddr_i] <= wdata_i;
    end

    // Taints must vanish with reset so a stale shadow never leaks into a fresh run.
    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            for (int i = 0; i < DEPTH; i++) taint_q[i] <= '0;
        end else if (we_i) begin
            taint_q[waddr_i] <= wtaint_i;
        end
    end

    assign rdata_o  = data_q[raddr_i];
    assign rtaint_o = taint_q[raddr_i];

endmodule

// File: rtl/taintcell_fifo.sv
// Synchronous FIFO with a per-bit taint shadow and occupancy taint.
// Define TAINTCELL_FIFO_TAINT_SUM_EN to build the tainted-entry counter.
module taintcell_fifo
    import pift_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                          pos_clk,
    input  logic                          pos_arst,
    input  logic                          push,
    input  logic                          push_taint,
    input  logic [WIDTH-1:0]              push_data,
    input  logic [WIDTH-1:0]              push_data_taint,
    input  logic                          pop,
    input  logic                          pop_taint,
    output logic [WIDTH-1:0]              pop_data,
    output logic [WIDTH-1:0]              pop_data_taint,
    output logic                          full,
    output logic                          empty,
    output logic                          occ_taint,
    output logic [pift_ptr_w(DEPTH):0]    count,
    output logic [pift_ptr_w(DEPTH):0]    taint_sum
);

    localparam int AW = pift_ptr_w(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             occ_q, occ_d;
    logic             push_acc, pop_acc;
    logic [WIDTH-1:0] wr_taint, rd_data, rd_taint, occ_wide;

    // push/pop are requests taken in the cycle they are high: a push is accepted
    // when not full, a pop when not empty, both judged on the pre-edge state.
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    assign wr_taint = push_data_taint | WIDTH'(pift_widen(push_taint));
    assign occ_wide = WIDTH'(pift_widen(occ_q));

    taintcell_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .pos_clk  (pos_clk),
        .pos_arst (pos_arst),
        .we_i     (push_acc),
        .waddr_i  (wptr_q),
        .wdata_i  (push_data),
        .wtaint_i (wr_taint),
        .raddr_i  (rptr_q),
        .rdata_o  (rd_data),
        .rtaint_o (rd_taint)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        occ_d   = occ_q;
        if (push_acc) wptr_d = wptr_q + AW'(1);
        if (pop_acc)  rptr_d = rptr_q + AW'(1);
        if (push_acc && !pop_acc) count_d = count_q + (AW+1)'(1);
        if (pop_acc && !push_acc) count_d = count_q - (AW+1)'(1);
        // A rejected request still leaks its control taint through the decision.
        if ((push && push_taint) || (pop && pop_taint)) begin
            occ_d = 1'b1;
        end else if (pop_acc && !push_acc && count_q == (AW+1)'(1)) begin
            occ_d = 1'b0;
        end
    end

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            occ_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            occ_q   <= occ_d;
        end
    end

`ifdef TAINTCELL_FIFO_TAINT_SUM_EN
    logic [AW:0] tsum_q, tsum_d;

    always_comb begin
        tsum_d = tsum_q;
        if (push_acc && (|wr_taint)) tsum_d = tsum_d + (AW+1)'(1);
        if (pop_acc && (|rd_taint))  tsum_d = tsum_d - (AW+1)'(1);
    end

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) tsum_q <= '0;
        else          tsum_q <= tsum_d;
    end

    assign taint_sum = tsum_q;
`else
    assign taint_sum = '0;
`endif

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign occ_taint = occ_q;
    assign pop_data  = rd_data;
    // Stale slots are masked when empty; occupancy taint still shows through.
    assign pop_data_taint = (empty ? '0 : rd_taint) | occ_wide;

endmodule

// File: tb/tb_taintcell_fifo.sv
// Directed bench for taintcell_fifo: queue model checked every cycle plus
// hand-computed literal expectations.
module tb_taintcell_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
`ifdef TAINTCELL_FIFO_TAINT_SUM_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             pos_clk;
  logic             pos_arst;
  logic             push, push_taint, pop, pop_taint;
  logic [WIDTH-1:0] push_data, push_data_taint;
  logic [WIDTH-1:0] pop_data, pop_data_taint;
  logic             full, empty, occ_taint;
  logic [3:0]       count, taint_sum;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] m_data[$];
  logic [WIDTH-1:0] m_taint[$];
  bit               m_occ;

  taintcell_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .pos_clk         (pos_clk),
    .pos_arst        (pos_arst),
    .push            (push),
    .push_taint      (push_taint),
    .push_data       (push_data),
    .push_data_taint (push_data_taint),
    .pop             (pop),
    .pop_taint       (pop_taint),
    .pop_data        (pop_data),
    .pop_data_taint  (pop_data_taint),
    .full            (full),
    .empty           (empty),
    .occ_taint       (occ_taint),
    .count           (count),
    .taint_sum       (taint_sum)
  );

  // clock / reset block
  initial begin
    pos_clk = 1'b0;
    forever #5 pos_clk = ~pos_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: FIFO contents as queues, occupancy taint as one bit
  task automatic model_reset();
    m_data.delete();
    m_taint.delete();
    m_occ = 1'b0;
  endtask

  task automatic model_step(input logic ps, pst, input logic [63:0] pd, pdt,
                            input logic pp, ppt);
    int  n;
    bit  pacc, oacc;
    n    = m_data.size();
    pacc = ps && (n < DEPTH);
    oacc = pp && (n > 0);
    if (oacc) begin
      void'(m_data.pop_front());
      void'(m_taint.pop_front());
    end
    if (pacc) begin
      m_data.push_back(pd);
      m_taint.push_back(pdt | (pst ? ONES : 64'h0));
    end
    if ((ps && pst) || (pp && ppt)) m_occ = 1'b1;
    else if (oacc && m_data.size() == 0) m_occ = 1'b0;
  endtask

  function automatic int model_tsum();
    int s;
    s = 0;
    foreach (m_taint[i]) if (m_taint[i] != 0) s++;
    return TS_EN ? s : 0;
  endfunction

  // scoreboard compare on the falling edge, away from the active edge
  always @(negedge pos_clk) begin
    chk("count", 64'(count), 64'(m_data.size()));
    chk("empty", 64'(empty), 64'(m_data.size() == 0));
    chk("full", 64'(full), 64'(m_data.size() == DEPTH));
    chk("occ_taint", 64'(occ_taint), 64'(m_occ));
    chk("taint_sum", 64'(taint_sum), 64'(model_tsum()));
    if (m_data.size() > 0) begin
      chk("pop_data", pop_data, m_data[0]);
      chk("pop_data_taint", pop_data_taint, m_taint[0] | (m_occ ? ONES : 64'h0));
    end else begin
      chk("pop_data_taint_empty", pop_data_taint, m_occ ? ONES : 64'h0);
    end
  end

  // driver: apply one cycle of requests, advance the model on the edge
  task automatic cycle(input logic ps, pst, input logic [63:0] pd, pdt,
                       input logic pp, ppt);
    push = ps; push_taint = pst; push_data = pd; push_data_taint = pdt;
    pop = pp; pop_taint = ppt;
    @(posedge pos_clk);
    model_step(ps, pst, pd, pdt, pp, ppt);
    #1;
    push = 1'b0; push_taint = 1'b0; pop = 1'b0; pop_taint = 1'b0;
  endtask

  task automatic do_push(input logic [63:0] d, t, input logic pt);
    cycle(1'b1, pt, d, t, 1'b0, 1'b0);
  endtask

  task automatic do_pop(input logic pt);
    cycle(1'b0, 1'b0, 64'h0, 64'h0, 1'b1, pt);
  endtask

  initial begin
    model_reset();
    pos_arst = 1'b1;
    push = 1'b0; push_taint = 1'b0; pop = 1'b0; pop_taint = 1'b0;
    push_data = '0; push_data_taint = '0;
    repeat (2) @(posedge pos_clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_occ", 64'(occ_taint), 64'd0);
    chk("rst_tsum", 64'(taint_sum), 64'd0);
    chk("rst_pdt", pop_data_taint, 64'h0);
    pos_arst = 1'b0;
    @(posedge pos_clk);
    #1;

    // single entry round trip
    do_push(64'hA5, 64'h0F, 1'b0);
    chk("rt_data", pop_data, 64'hA5);
    chk("rt_taint", pop_data_taint, 64'h0F);
    chk("rt_count", 64'(count), 64'd1);
    chk("rt_tsum", 64'(taint_sum), TS_EN ? 64'd1 : 64'd0);
    do_pop(1'b0);
    chk("rt_empty", 64'(empty), 64'd1);
    chk("rt_tsum0", 64'(taint_sum), 64'd0);

    // fill, overfill, push+pop on full, refill and drain across the wrap
    for (int i = 0; i < DEPTH; i++) do_push(64'h10 + 64'(i), 64'h0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd8);
    do_push(64'h99, 64'h0, 1'b0);
    chk("over_count", 64'(count), 64'd8);
    chk("over_head", pop_data, 64'h10);
    cycle(1'b1, 1'b0, 64'hAA, 64'h0, 1'b1, 1'b0);
    chk("pp_full_count", 64'(count), 64'd7);
    chk("pp_full_full", 64'(full), 64'd0);
    chk("pp_full_head", pop_data, 64'h11);
    do_push(64'hB0, 64'h0, 1'b0);
    chk("refill_count", 64'(count), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", pop_data, (i == DEPTH - 1) ? 64'hB0 : 64'h11 + 64'(i));
      do_pop(1'b0);
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // control-tainted push widens every pop until an untainted pop empties
    do_push(64'h55, 64'h0, 1'b1);
    chk("ctl_stored", pop_data_taint, ONES);
    chk("ctl_occ", 64'(occ_taint), 64'd1);
    do_push(64'h66, 64'h3, 1'b0);
    do_pop(1'b0);
    chk("ctl_widened", pop_data_taint, ONES);
    chk("ctl_data", pop_data, 64'h66);
    do_pop(1'b0);
    chk("ctl_clear", 64'(occ_taint), 64'd0);
    chk("ctl_pdt0", pop_data_taint, 64'h0);

    // tainted pop on empty is rejected but taints occupancy
    do_pop(1'b1);
    chk("epop_count", 64'(count), 64'd0);
    chk("epop_occ", 64'(occ_taint), 64'd1);
    chk("epop_pdt", pop_data_taint, ONES);

    // push+pop on empty: push wins; then clear occupancy taint
    cycle(1'b1, 1'b0, 64'h77, 64'h0, 1'b1, 1'b0);
    chk("pp_empty_count", 64'(count), 64'd1);
    chk("pp_empty_data", pop_data, 64'h77);
    do_pop(1'b0);
    chk("pp_empty_occ", 64'(occ_taint), 64'd0);

    // rejected tainted push on full still taints occupancy
    for (int i = 0; i < DEPTH; i++) do_push(64'h20 + 64'(i), 64'h0, 1'b0);
    do_push(64'hEE, 64'h0, 1'b1);
    chk("fpush_occ", 64'(occ_taint), 64'd1);
    chk("fpush_count", 64'(count), 64'd8);
    for (int i = 0; i < DEPTH; i++) do_pop(1'b0);
    chk("fpush_clear", 64'(occ_taint), 64'd0);

    // async reset between edges with three tainted entries
    do_push(64'h1, 64'h1, 1'b0);
    do_push(64'h2, 64'h2, 1'b1);
    do_push(64'h3, 64'h4, 1'b0);
    #2;
    pos_arst = 1'b1;
    model_reset();
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_tsum", 64'(taint_sum), 64'd0);
    chk("arst_occ", 64'(occ_taint), 64'd0);
    chk("arst_pdt", pop_data_taint, 64'h0);
    @(posedge pos_clk);
    #1;
    pos_arst = 1'b0;
    @(posedge pos_clk);
    #1;

    // four tainted entries: counter present only in the enabled build
    for (int i = 0; i < 4; i++) do_push(64'h40 + 64'(i), 64'h1 << i, 1'b0);
    chk("ts4_tsum", 64'(taint_sum), TS_EN ? 64'd4 : 64'd0);
    chk("ts4_count", 64'(count), 64'd4);
    chk("ts4_head_taint", pop_data_taint, 64'h1);
    do_pop(1'b0);
    chk("ts4_tsum_pop", 64'(taint_sum), TS_EN ? 64'd3 : 64'd0);
    chk("ts4_head_taint2", pop_data_taint, 64'h2);

    @(negedge pos_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
